// File: rtl/aes_seq_pkg.sv
// Shared encodings for the mailbox-RAM AES sequencer: FSM states, mailbox word map,
// control/status bit positions and byte-enable patterns.
package aes_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_KEY,
    ST_PT,
    ST_START,
    ST_WAIT,
    ST_WR_CT,
    ST_WR_ST
  } state_e;

  localparam logic [1:0] ADDR_KEY  = 2'd0;
  localparam logic [1:0] ADDR_PT   = 2'd1;
  localparam logic [1:0] ADDR_CT   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int unsigned BIT_START = 0;
  localparam int unsigned BIT_BUSY  = 1;
  localparam int unsigned BIT_DONE  = 2;
  localparam int unsigned BIT_ERR   = 3;

  localparam logic [15:0] BE_CTRL   = 16'h0001;
  localparam logic [15:0] BE_STATUS = 16'h00FF;
  localparam logic [15:0] BE_ALL    = 16'hFFFF;

  // Control word with only BUSY set; written when a job is accepted.
  function automatic logic [127:0] busy_word();
    logic [7:0] s;
    s           = '0;
    s[BIT_BUSY] = 1'b1;
    return {120'd0, s};
  endfunction

  // Final status word: DONE plus optional ERR in byte 0, job count in bytes 4..7.
  function automatic logic [127:0] status_word(input logic err, input logic [31:0] jobs);
    logic [7:0] s;
    s           = '0;
    s[BIT_DONE] = 1'b1;
    s[BIT_ERR]  = err;
    return {64'd0, jobs, 24'd0, s};
  endfunction

endpackage

// File: rtl/soc_system_aes_mem_sequencer.sv
// Port-2 master of the HPS mailbox RAM: polls for a start request, feeds key and
// plaintext to the AES core, writes back the ciphertext and posts DONE/ERR status.
module soc_system_aes_mem_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned POLL_GAP      = 16,
  parameter int unsigned TIMEOUT       = 4096,
  parameter int unsigned RD_LAT        = 1,
  parameter logic [31:0] JOB_COUNT_RST = 32'h0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  output logic [1:0]   mem_address,
  output logic         mem_chipselect,
  output logic         mem_write,
  output logic [15:0]  mem_byteenable,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  output logic         mem_clken,
  output logic [127:0] aes_key,
  output logic [127:0] aes_din,
  output logic         aes_start,
  input  logic [127:0] aes_dout,
  input  logic         aes_done,
  output logic         busy,
  output logic         irq,
  output logic [31:0]  job_count
);

  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  state_e             state_q;
  logic [GAP_W-1:0]   gap_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [LAT_W-1:0]   lat_q;
  logic [1:0]         addr_q;
  logic               cs_q;
  logic               we_q;
  logic [15:0]        be_q;
  logic [127:0]       wdata_q;
  logic               clken_q;
  logic [127:0]       key_q;
  logic [127:0]       din_q;
  logic               start_q;
  logic               busy_q;
  logic               irq_q;
  logic [31:0]        jobs_q;
  logic [31:0]        jobs_inc_d;
  logic               rd_valid_c;

  assign jobs_inc_d = jobs_q + 32'd1;
  assign rd_valid_c = (lat_q == LAT_W'(RD_LAT));

  // Sequencer FSM; bus strobes default low so at most one access is issued per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      tmo_q   <= '0;
      lat_q   <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      clken_q <= 1'b0;
      key_q   <= '0;
      din_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
      jobs_q  <= JOB_COUNT_RST;
    end else begin
      clken_q <= 1'b1;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      start_q <= 1'b0;
      irq_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
            if (gap_q == GAP_W'(POLL_GAP - 1)) begin
              gap_q   <= '0;
              lat_q   <= '0;
              addr_q  <= ADDR_CTRL;
              cs_q    <= 1'b1;
              be_q    <= BE_ALL;
              state_q <= ST_POLL;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
        end
        ST_POLL: begin
          if (!rd_valid_c) begin
            lat_q <= lat_q + LAT_W'(1);
          end else if (mem_readdata[BIT_START]) begin
            addr_q  <= ADDR_CTRL;
            cs_q    <= 1'b1;
            we_q    <= 1'b1;
            be_q    <= BE_CTRL;
            wdata_q <= busy_word();
            busy_q  <= 1'b1;
            state_q <= ST_KEY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_KEY: begin
          // First KEY cycle carries the BUSY write, so the key read is issued one cycle later.
          if (we_q) begin
            addr_q <= ADDR_KEY;
            cs_q   <= 1'b1;
            be_q   <= BE_ALL;
            lat_q  <= '0;
          end else if (rd_valid_c) begin
            key_q   <= mem_readdata;
            addr_q  <= ADDR_PT;
            cs_q    <= 1'b1;
            be_q    <= BE_ALL;
            lat_q   <= '0;
            state_q <= ST_PT;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        ST_PT: begin
          if (rd_valid_c) begin
            din_q   <= mem_readdata;
            start_q <= 1'b1;
            state_q <= ST_START;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        ST_START: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (aes_done) begin
            addr_q  <= ADDR_CT;
            cs_q    <= 1'b1;
            we_q    <= 1'b1;
            be_q    <= BE_ALL;
            wdata_q <= aes_dout;
            state_q <= ST_WR_CT;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            addr_q  <= ADDR_CTRL;
            cs_q    <= 1'b1;
            we_q    <= 1'b1;
            be_q    <= BE_STATUS;
            wdata_q <= status_word(1'b1, jobs_q);
            irq_q   <= 1'b1;
            state_q <= ST_WR_ST;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_WR_CT: begin
          addr_q  <= ADDR_CTRL;
          cs_q    <= 1'b1;
          we_q    <= 1'b1;
          be_q    <= BE_STATUS;
          wdata_q <= status_word(1'b0, jobs_inc_d);
          jobs_q  <= jobs_inc_d;
          irq_q   <= 1'b1;
          state_q <= ST_WR_ST;
        end
        ST_WR_ST: begin
          busy_q  <= 1'b0;
          gap_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = we_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wdata_q;
  assign mem_clken      = clken_q;
  assign aes_key        = key_q;
  assign aes_din        = din_q;
  assign aes_start      = start_q;
  assign busy           = busy_q;
  assign irq            = irq_q;
  assign job_count      = jobs_q;

endmodule

// File: tb/tb_soc_system_aes_mem_sequencer.sv
// Bench for the AES mailbox sequencer: two instances (default and near-wrap job counter)
// each with a mailbox RAM model and a stand-in AES core; results scored against a job-level model.
module tb_soc_system_aes_mem_sequencer;

  localparam int unsigned POLL_GAP = 16;
  localparam int unsigned TIMEOUT  = 4096;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  int   core_lat = 10;
  logic core_hang = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in cipher: the FIPS-197 vector for the reference inputs, an arbitrary mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_K && p == FIPS_P) return FIPS_C;
    return {k[63:0] ^ p[127:64], k[127:64] + p[63:0]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [1:0]   mem_address;
    logic         mem_chipselect, mem_write, mem_clken;
    logic [15:0]  mem_byteenable;
    logic [127:0] mem_writedata, mem_readdata;
    logic [127:0] aes_key, aes_din, aes_dout;
    logic         aes_start, busy, irq;
    logic         aes_done = 1'b0;
    logic [31:0]  job_count;
    logic [127:0] ram [4];
    logic [1:0]   rd_addr;
    logic         hps_we = 1'b0;
    logic [1:0]   hps_addr = 2'd0;
    logic [127:0] hps_data = '0;
    int           remaining = 0;
    logic [127:0] k_s, p_s;

    soc_system_aes_mem_sequencer #(
      .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT), .RD_LAT(1),
      .JOB_COUNT_RST((g == 0) ? 32'h0 : 32'hFFFF_FFFF)
    ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .mem_clken(mem_clken),
      .aes_key(aes_key), .aes_din(aes_din), .aes_start(aes_start),
      .aes_dout(aes_dout), .aes_done(aes_done),
      .busy(busy), .irq(irq), .job_count(job_count)
    );

    // Mailbox RAM: registered read address, byte-enabled writes, plus an HPS-side write port.
    assign mem_readdata = ram[rd_addr];
    always @(posedge clk) begin
      if (mem_clken && mem_chipselect && !mem_write) rd_addr <= mem_address;
      if (mem_clken && mem_chipselect && mem_write)
        for (int b = 0; b < 16; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      if (hps_we) ram[hps_addr] <= hps_data;
    end

    // AES core stand-in with programmable latency, or silent when core_hang is set.
    always @(posedge clk) begin
      aes_done <= 1'b0;
      if (aes_start && !core_hang) begin
        remaining <= core_lat;
        k_s <= aes_key;
        p_s <= aes_din;
      end else if (remaining > 0) begin
        remaining <= remaining - 1;
        if (remaining == 1) begin
          aes_done <= 1'b1;
          aes_dout <= core_fn(k_s, p_s);
        end
      end
    end

    always @(negedge clk) begin
      if (aes_done) begin
        chk($sformatf("key_hold%0d", g), aes_key, k_s);
        chk($sformatf("din_hold%0d", g), aes_din, p_s);
      end
    end
  end

  // Bus monitor on instance 0.
  int   cyc = 0, last_poll = -1, min_gap = 1000000, max_gap = 0;
  int   polls = 0, writes = 0, irqs = 0;
  logic busy_seen = 1'b0;
  logic drop_on_key = 1'b0;
  int   exp_jobs = 0;

  always @(negedge clk) begin
    cyc++;
    if (g_inst[0].mem_chipselect && !g_inst[0].mem_write && g_inst[0].mem_address == 2'd3) begin
      if (last_poll >= 0) begin
        if (cyc - last_poll < min_gap) min_gap = cyc - last_poll;
        if (cyc - last_poll > max_gap) max_gap = cyc - last_poll;
      end
      last_poll = cyc;
      polls++;
    end
    if (g_inst[0].mem_chipselect && g_inst[0].mem_write) writes++;
    if (g_inst[0].irq) irqs++;
    if (g_inst[0].busy) busy_seen = 1'b1;
    if (drop_on_key && g_inst[0].mem_chipselect && !g_inst[0].mem_write &&
        g_inst[0].mem_address == 2'd0) begin
      enable = 1'b0;
      drop_on_key = 1'b0;
    end
  end

  task automatic clear_mon();
    last_poll = -1; min_gap = 1000000; max_gap = 0;
    polls = 0; writes = 0; irqs = 0; busy_seen = 1'b0;
  endtask

  task automatic hps_write(input int inst, input logic [1:0] a, input logic [127:0] d);
    @(negedge clk);
    if (inst == 0) begin
      g_inst[0].hps_addr = a; g_inst[0].hps_data = d; g_inst[0].hps_we = 1'b1;
    end else begin
      g_inst[1].hps_addr = a; g_inst[1].hps_data = d; g_inst[1].hps_we = 1'b1;
    end
    @(negedge clk);
    g_inst[0].hps_we = 1'b0;
    g_inst[1].hps_we = 1'b0;
  endtask

  task automatic wait_irq(input int inst, input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (inst == 0) ? g_inst[0].irq : g_inst[1].irq;
    end
    chk({tag, "_irq_seen"}, 128'(seen), 128'd1);
  endtask

  // One job on instance 0, scored against the job-level expectation.
  task automatic run_job(input logic [127:0] key, input logic [127:0] pt, input logic [63:0] hdr,
                         input int lat, input logic hang, input string tag);
    logic [127:0] sentinel, exp2, exp3;
    sentinel  = {$urandom, $urandom, $urandom, $urandom};
    core_lat  = lat;
    core_hang = hang;
    hps_write(0, 2'd2, sentinel);
    hps_write(0, 2'd0, key);
    hps_write(0, 2'd1, pt);
    clear_mon();
    hps_write(0, 2'd3, {hdr, 56'd0, 8'h01});
    wait_irq(0, TIMEOUT + 500, tag);
    if (!hang) begin
      exp_jobs++;
      exp2 = core_fn(key, pt);
      exp3 = {hdr, 32'(exp_jobs), 24'd0, 8'h04};
    end else begin
      exp2 = sentinel;
      exp3 = {hdr, 32'(exp_jobs), 24'd0, 8'h0C};
    end
    repeat (3) @(negedge clk);
    chk({tag, "_word2"}, g_inst[0].ram[2], exp2);
    chk({tag, "_word3"}, g_inst[0].ram[3], exp3);
    chk({tag, "_job_count"}, 128'(g_inst[0].job_count), 128'(32'(exp_jobs)));
    chk({tag, "_irq_pulses"}, 128'(irqs), 128'd1);
    chk({tag, "_busy_low"}, 128'(g_inst[0].busy), 128'd0);
    chk({tag, "_writes"}, 128'(writes), hang ? 128'd2 : 128'd3);
  endtask

  initial begin
    logic seen;
    // Reset phase and RAM initialisation.
    for (int i = 0; i < 4; i++) begin
      hps_write(0, 2'(i), '0);
      hps_write(1, 2'(i), '0);
    end
    chk("rst_cs", 128'(g_inst[0].mem_chipselect), 128'd0);
    chk("rst_clken", 128'(g_inst[0].mem_clken), 128'd0);
    chk("rst_busy", 128'(g_inst[0].busy), 128'd0);
    chk("rst_job0", 128'(g_inst[0].job_count), 128'd0);
    chk("rst_job1", 128'(g_inst[1].job_count), 128'hFFFF_FFFF);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("clken_after_rst", 128'(g_inst[0].mem_clken), 128'd1);
    enable = 1'b1;

    run_job(FIPS_K, FIPS_P, 64'd0, 10, 1'b0, "fips");

    for (int n = 0; n < 4; n++)
      run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom}, int'($urandom_range(1, 30)), 1'b0, $sformatf("rand%0d", n));

    // Idle polling with START clear.
    clear_mon();
    repeat (200) @(negedge clk);
    chk("idle_polls", 128'(polls >= 10), 128'd1);
    chk("idle_writes", 128'(writes), 128'd0);
    chk("idle_busy", 128'(busy_seen), 128'd0);
    chk("poll_gap_min", 128'(min_gap >= int'(POLL_GAP) + 1), 128'd1);
    chk("poll_gap_max", 128'(max_gap <= int'(POLL_GAP) + 2), 128'd1);

    run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom}, 0, 1'b1, "timeout");
    core_hang = 1'b0;

    // enable dropped while the key is being read.
    drop_on_key = 1'b1;
    run_job({$urandom, $urandom, $urandom, $urandom}, FIPS_P, 64'd0, 7, 1'b0, "en_drop");
    clear_mon();
    repeat (100) @(negedge clk);
    chk("en_drop_no_polls", 128'(polls), 128'd0);
    enable = 1'b1;

    // Reset while the core is busy.
    core_hang = 1'b1;
    hps_write(0, 2'd0, FIPS_K);
    hps_write(0, 2'd1, FIPS_P);
    hps_write(0, 2'd3, 128'h1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = g_inst[0].aes_start;
    end
    chk("mid_rst_start_seen", 128'(seen), 128'd1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", 128'({g_inst[0].mem_chipselect, g_inst[0].mem_write, g_inst[0].busy,
                              g_inst[0].irq, g_inst[0].aes_start, g_inst[0].mem_clken,
                              g_inst[0].mem_address, g_inst[0].mem_byteenable}), 128'd0);
    chk("mid_rst_key", g_inst[0].aes_key, 128'd0);
    chk("mid_rst_din", g_inst[0].aes_din, 128'd0);
    chk("mid_rst_wdata", g_inst[0].mem_writedata, 128'd0);
    chk("mid_rst_jobs", 128'(g_inst[0].job_count), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_jobs = 0;
    core_hang = 1'b0;
    clear_mon();
    for (int i = 0; i < 100 && polls == 0; i++) @(negedge clk);
    chk("post_rst_poll_seen", 128'(polls > 0), 128'd1);
    chk("post_rst_no_write", 128'(writes), 128'd0);

    run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom}, 3, 1'b0, "post_rst");

    // Job counter wrap on the second instance.
    hps_write(1, 2'd0, FIPS_K);
    hps_write(1, 2'd1, FIPS_P);
    core_lat = 5;
    hps_write(1, 2'd3, 128'h1);
    wait_irq(1, 300, "wrap");
    repeat (3) @(negedge clk);
    chk("wrap_job_count", 128'(g_inst[1].job_count), 128'd0);
    chk("wrap_word3", g_inst[1].ram[3], 128'h04);
    chk("wrap_word2", g_inst[1].ram[2], FIPS_C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
